pipeline_execute_stage: RTL and testbench
=========================================

PIPELINE_EXECUTE_STAGE -- requirements
Module: pipeline_execute_stage

Interface
REQ-001 Ports SHALL be one per line, clock and reset first: CLK  in  1  sole clock, rising edge; RST  in  1  reset, synchronous, active-high.
REQ-002 Decode/execute inputs: valid_E in 1 instruction present; PC_instr_E in 32 instruction PC; PC_plus4_E in 32; rs1_E in 32; rs2_E in 32; immed_ext_E in 32.
REQ-003 Control inputs: regWrite_E, memWrite_E, memRead2_E, jump_E, branch_E in 1 each; alu_fun_E in 3; alu_mod_E in 1 (SUB/SRA select); alu_srcB_E in 2; rf_wr_sel_E in 2; br_cond_E in 3 (RV32 funct3).
REQ-004 Hazard inputs: stall_M in 1 hold E/M register; flush_E in 1 external kill of the current E instruction.
REQ-005 Redirect outputs: redirect_E out 1 taken branch/jump; target_E out 32 next-fetch address; squash_D out 1 kill the instruction now in decode.
REQ-006 Execute/memory outputs: valid_M out 1; PC_instr_M, PC_plus4_M, alu_result_M, rs2_M out 32 each; regWrite_M, memWrite_M, memRead2_M out 1 each; rf_wr_sel_M out 2.

Function
REQ-007 alu_fun_E encoding: 0 ADD/SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND; alu_mod_E=1 selects SUB at 0 and SRA at 5, ignored elsewhere.
REQ-008 Operand B: alu_srcB_E 00 rs2, 01 immed; 10 immed with operand A = PC_instr_E; 11 treated as 00.
REQ-009 Shift amount SHALL be operand B[4:0]; all arithmetic 32-bit, wrap-around, no overflow flag.
REQ-010 Branch compare on rs1_E/rs2_E per br_cond_E: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
REQ-011 live_E = valid_E & ~flush_E & ~kill, where kill is the FSM squash of REQ-014.
REQ-012 redirect_E (combinational) = live_E & (jump_E | (branch_E & taken)).
REQ-013 target_E = jump_E ? alu result with bit 0 cleared : PC_instr_E + immed_ext_E.
REQ-014 Squash FSM states RUN, SQ1: RUN->SQ1 when redirect_E & ~stall_M; SQ1->RUN on the next non-stalled cycle; in SQ1 kill=1 (wrong-path fetch reaching E is killed); redirect in SQ1 is impossible as live_E=0.
REQ-015 squash_D SHALL equal redirect_E; the fetch/decode register consumes it the same cycle.
REQ-016 E/M register, on each rising edge with ~stall_M: valid_M<=live_E; data/control fields <= E values; regWrite_M, memWrite_M, memRead2_M <= value & live_E.
REQ-017 stall_M=1: all E/M outputs and FSM state hold; redirect_E still computed but the FSM does not advance.
REQ-018 Latency: E inputs appear at M outputs one edge later; redirect is zero-cycle.
REQ-019 flush_E and stall_M simultaneous: stall wins for the register; flush only affects live_E.

Reset
REQ-020 RST=1 at an edge: valid_M, regWrite_M, memWrite_M, memRead2_M <=0; all 32-bit outputs and rf_wr_sel_M <=0; FSM <=RUN; overrides stall_M.
REQ-021 Reset mid-squash SHALL return FSM to RUN with no pending kill.

Structure
REQ-022 alu_fun, alu_srcB, rf_wr_sel, br_cond encodings and the FSM state enum SHALL live in the shared otter pipeline package.
REQ-023 ALU SHALL be one sub-module, otter_alu (combinational); branch compare, FSM and E/M register stay in this module.

Verification
REQ-024 ADD: rs1=5, immed=-7, alu_srcB=01, valid_E=1 -> next edge alu_result_M=0xFFFFFFFE, valid_M=1.
REQ-025 BEQ taken: rs1=rs2=3, PC=0x100, immed=0x20 -> redirect_E=1, target_E=0x120; next-cycle valid_E instruction gives valid_M=0, regWrite_M=0.
REQ-026 JALR: rs1=0x203, immed=0, jump_E=1, rf_wr_sel=PC+4 -> target_E=0x202, PC_plus4_M forwarded, regWrite_M=1.
REQ-027 stall_M held 3 cycles with redirect pending -> outputs frozen, FSM stays RUN, then SQ1 after release.
REQ-028 RST asserted while in SQ1 with memWrite_M=1 -> next edge memWrite_M=0, valid_M=0, FSM RUN.
REQ-029 SRA: rs1=0x80000000, rs2=4, alu_fun=5, alu_mod=1 -> alu_result_M=0xF8000000; alu_mod=0 -> 0x08000000.

Source files
------------

// File: rtl/pipeline_execute_stage_pkg.sv
// rtl/pipeline_execute_stage_pkg.sv - shared otter pipeline encodings for the execute stage
package pipeline_execute_stage_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SRL  = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_fun_t;

    // SRCB_PC_IMM also swaps operand A to the instruction PC (AUIPC/JAL)
    typedef enum logic [1:0] {
        SRCB_RS2    = 2'd0,
        SRCB_IMM    = 2'd1,
        SRCB_PC_IMM = 2'd2,
        SRCB_RS2_B  = 2'd3
    } alu_srcb_t;

    typedef enum logic [1:0] {
        WR_SEL_PC4 = 2'd0,
        WR_SEL_CSR = 2'd1,
        WR_SEL_MEM = 2'd2,
        WR_SEL_ALU = 2'd3
    } rf_wr_sel_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_cond_t;

    typedef enum logic {
        SQ_RUN = 1'b0,
        SQ_SQ1 = 1'b1
    } squash_state_t;

    function automatic logic branch_taken(input logic [2:0] cond,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (cond)
            BR_EQ:   return a == b;
            BR_NE:   return a != b;
            BR_LT:   return $signed(a) < $signed(b);
            BR_GE:   return $signed(a) >= $signed(b);
            BR_LTU:  return a < b;
            BR_GEU:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_execute_stage_if.sv
// rtl/pipeline_execute_stage_if.sv - decode-to-execute, hazard, redirect and E/M bundle
interface pipeline_execute_stage_if;
    logic        valid_E;
    logic [31:0] PC_instr_E;
    logic [31:0] PC_plus4_E;
    logic [31:0] rs1_E;
    logic [31:0] rs2_E;
    logic [31:0] immed_ext_E;
    logic        regWrite_E;
    logic        memWrite_E;
    logic        memRead2_E;
    logic        jump_E;
    logic        branch_E;
    logic [2:0]  alu_fun_E;
    logic        alu_mod_E;
    logic [1:0]  alu_srcB_E;
    logic [1:0]  rf_wr_sel_E;
    logic [2:0]  br_cond_E;
    logic        stall_M;
    logic        flush_E;

    logic        redirect_E;
    logic [31:0] target_E;
    logic        squash_D;

    logic        valid_M;
    logic [31:0] PC_instr_M;
    logic [31:0] PC_plus4_M;
    logic [31:0] alu_result_M;
    logic [31:0] rs2_M;
    logic        regWrite_M;
    logic        memWrite_M;
    logic        memRead2_M;
    logic [1:0]  rf_wr_sel_M;

    modport master (
        output valid_E, PC_instr_E, PC_plus4_E, rs1_E, rs2_E, immed_ext_E,
        output regWrite_E, memWrite_E, memRead2_E, jump_E, branch_E,
        output alu_fun_E, alu_mod_E, alu_srcB_E, rf_wr_sel_E, br_cond_E,
        output stall_M, flush_E,
        input  redirect_E, target_E, squash_D,
        input  valid_M, PC_instr_M, PC_plus4_M, alu_result_M, rs2_M,
        input  regWrite_M, memWrite_M, memRead2_M, rf_wr_sel_M
    );

    modport slave (
        input  valid_E, PC_instr_E, PC_plus4_E, rs1_E, rs2_E, immed_ext_E,
        input  regWrite_E, memWrite_E, memRead2_E, jump_E, branch_E,
        input  alu_fun_E, alu_mod_E, alu_srcB_E, rf_wr_sel_E, br_cond_E,
        input  stall_M, flush_E,
        output redirect_E, target_E, squash_D,
        output valid_M, PC_instr_M, PC_plus4_M, alu_result_M, rs2_M,
        output regWrite_M, memWrite_M, memRead2_M, rf_wr_sel_M
    );
endinterface

// File: rtl/pipeline_execute_stage_alu.sv
// rtl/pipeline_execute_stage_alu.sv - combinational RV32 integer ALU (otter_alu)
module otter_alu
    import pipeline_execute_stage_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  alu_fun,
    input  logic        alu_mod,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = op_b[4:0];

    always_comb begin
        result = '0;
        case (alu_fun)
            ALU_ADD:  result = alu_mod ? (op_a - op_b) : (op_a + op_b);
            ALU_SLL:  result = op_a << shamt;
            ALU_SLT:  result = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: result = {31'b0, op_a < op_b};
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SRL:  result = alu_mod ? 32'($signed(op_a) >>> shamt) : (op_a >> shamt);
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_execute_stage.sv
// rtl/pipeline_execute_stage.sv - execute stage: ALU, branch resolve, squash FSM, E/M register
module pipeline_execute_stage
    import pipeline_execute_stage_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    pipeline_execute_stage_if.slave  ex
);

    squash_state_t state;
    logic          use_pc;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic [31:0]   alu_result;
    logic          taken;
    logic          kill;
    logic          live;
    logic          redirect;

    assign use_pc = (ex.alu_srcB_E == SRCB_PC_IMM);
    assign op_a   = use_pc ? ex.PC_instr_E : ex.rs1_E;
    assign op_b   = (use_pc || ex.alu_srcB_E == SRCB_IMM) ? ex.immed_ext_E : ex.rs2_E;

    otter_alu u_alu (
        .op_a    (op_a),
        .op_b    (op_b),
        .alu_fun (ex.alu_fun_E),
        .alu_mod (ex.alu_mod_E),
        .result  (alu_result)
    );

    assign taken    = branch_taken(ex.br_cond_E, ex.rs1_E, ex.rs2_E);
    // The instruction in E during SQ1 was fetched down the wrong path
    assign kill     = (state == SQ_SQ1);
    assign live     = ex.valid_E & ~ex.flush_E & ~kill;
    assign redirect = live & (ex.jump_E | (ex.branch_E & taken));

    assign ex.redirect_E = redirect;
    assign ex.squash_D   = redirect;
    assign ex.target_E   = ex.jump_E ? {alu_result[31:1], 1'b0}
                                     : (ex.PC_instr_E + ex.immed_ext_E);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= SQ_RUN;
            ex.valid_M      <= 1'b0;
            ex.PC_instr_M   <= '0;
            ex.PC_plus4_M   <= '0;
            ex.alu_result_M <= '0;
            ex.rs2_M        <= '0;
            ex.regWrite_M   <= 1'b0;
            ex.memWrite_M   <= 1'b0;
            ex.memRead2_M   <= 1'b0;
            ex.rf_wr_sel_M  <= '0;
        end else if (!ex.stall_M) begin
            case (state)
                SQ_RUN:  state <= redirect ? SQ_SQ1 : SQ_RUN;
                SQ_SQ1:  state <= SQ_RUN;
                default: state <= SQ_RUN;
            endcase
            ex.valid_M      <= live;
            ex.PC_instr_M   <= ex.PC_instr_E;
            ex.PC_plus4_M   <= ex.PC_plus4_E;
            ex.alu_result_M <= alu_result;
            ex.rs2_M        <= ex.rs2_E;
            ex.regWrite_M   <= ex.regWrite_E & live;
            ex.memWrite_M   <= ex.memWrite_E & live;
            ex.memRead2_M   <= ex.memRead2_E & live;
            ex.rf_wr_sel_M  <= ex.rf_wr_sel_E;
        end
    end

endmodule

// File: tb/tb_pipeline_execute_stage.sv
// tb/tb_pipeline_execute_stage.sv - scoreboard bench for pipeline_execute_stage
module tb_pipeline_execute_stage;
    import pipeline_execute_stage_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pipeline_execute_stage_if bus ();

    pipeline_execute_stage dut (
        .CLK (CLK),
        .RST (RST),
        .ex  (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic        rw;
        logic        mw;
        logic        mr;
        logic [1:0]  sel;
    } mexp_t;

    mexp_t scb[$];
    mexp_t last;
    mexp_t zero_m;
    int    n_chk  = 0;
    int    n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic mexp_t mk(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic rw, input logic mw,
                                 input logic mr, input logic [1:0] sel);
        mexp_t m;
        m.valid = v;   m.pc = pc;  m.pc4 = pc + 32'd4; m.alu = alu; m.rs2 = rs2;
        m.rw    = rw;  m.mw = mw;  m.mr  = mr;         m.sel = sel;
        return m;
    endfunction

    task automatic clr();
        RST = 1'b0;
        bus.valid_E = 0; bus.PC_instr_E = 0; bus.PC_plus4_E = 0; bus.rs1_E = 0; bus.rs2_E = 0;
        bus.immed_ext_E = 0; bus.regWrite_E = 0; bus.memWrite_E = 0; bus.memRead2_E = 0;
        bus.jump_E = 0; bus.branch_E = 0; bus.alu_fun_E = 0; bus.alu_mod_E = 0;
        bus.alu_srcB_E = 0; bus.rf_wr_sel_E = 0; bus.br_cond_E = 0; bus.stall_M = 0; bus.flush_E = 0;
    endtask

    task automatic op(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [2:0] fun, input logic md,
                      input logic [1:0] srcb);
        clr();
        bus.valid_E = 1; bus.PC_instr_E = pc; bus.PC_plus4_E = pc + 32'd4;
        bus.rs1_E = rs1; bus.rs2_E = rs2; bus.immed_ext_E = imm;
        bus.alu_fun_E = fun; bus.alu_mod_E = md; bus.alu_srcB_E = srcb;
    endtask

    // Inputs are already applied; check the zero-cycle outputs, queue the E/M expectation.
    task automatic cycle(input string tag, input logic exp_redir, input logic chk_tgt,
                         input logic [31:0] exp_tgt, input mexp_t exp_m);
        #1;
        chk({tag, ".redirect_E"}, 32'(bus.redirect_E), 32'(exp_redir));
        chk({tag, ".squash_D"}, 32'(bus.squash_D), 32'(exp_redir));
        if (chk_tgt) chk({tag, ".target_E"}, bus.target_E, exp_tgt);
        scb.push_back(exp_m);
        last = exp_m;
        @(negedge CLK);
    endtask

    initial begin : monitor
        mexp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (scb.size() > 0) begin
                e = scb.pop_front();
                chk("valid_M",      32'(bus.valid_M),      32'(e.valid));
                chk("PC_instr_M",   bus.PC_instr_M,        e.pc);
                chk("PC_plus4_M",   bus.PC_plus4_M,        e.pc4);
                chk("alu_result_M", bus.alu_result_M,      e.alu);
                chk("rs2_M",        bus.rs2_M,             e.rs2);
                chk("regWrite_M",   32'(bus.regWrite_M),   32'(e.rw));
                chk("memWrite_M",   32'(bus.memWrite_M),   32'(e.mw));
                chk("memRead2_M",   32'(bus.memRead2_M),   32'(e.mr));
                chk("rf_wr_sel_M",  32'(bus.rf_wr_sel_M),  32'(e.sel));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        zero_m = '0;
        clr();
        RST = 1'b1;
        @(negedge CLK);

        // Reset, then reset overriding a stall with a writing instruction present
        clr(); RST = 1;
        cycle("rst0", 0, 0, 0, zero_m);
        op(32'h10, 32'd5, 32'd1, 32'd0, ALU_ADD, 0, SRCB_RS2);
        bus.regWrite_E = 1; bus.stall_M = 1; RST = 1;
        cycle("rst1", 0, 0, 0, zero_m);

        // ALU operations
        op(32'h40, 32'd5, 32'h11, 32'hFFFF_FFF9, ALU_ADD, 0, SRCB_IMM);
        bus.regWrite_E = 1; bus.rf_wr_sel_E = WR_SEL_ALU;
        cycle("add", 0, 0, 0, mk(1, 32'h40, 32'hFFFF_FFFE, 32'h11, 1, 0, 0, 2'd3));
        op(32'h44, 32'd10, 32'd3, 32'd0, ALU_ADD, 1, SRCB_RS2);
        cycle("sub", 0, 0, 0, mk(1, 32'h44, 32'd7, 32'd3, 0, 0, 0, 2'd0));
        op(32'h48, 32'h8000_0000, 32'd4, 32'd0, ALU_SRL, 1, SRCB_RS2);
        cycle("sra", 0, 0, 0, mk(1, 32'h48, 32'hF800_0000, 32'd4, 0, 0, 0, 2'd0));
        op(32'h4C, 32'h8000_0000, 32'd4, 32'd0, ALU_SRL, 0, SRCB_RS2);
        cycle("srl", 0, 0, 0, mk(1, 32'h4C, 32'h0800_0000, 32'd4, 0, 0, 0, 2'd0));
        op(32'h50, 32'hFFFF_FFFF, 32'd1, 32'd0, ALU_SLT, 0, SRCB_RS2);
        cycle("slt", 0, 0, 0, mk(1, 32'h50, 32'd1, 32'd1, 0, 0, 0, 2'd0));
        op(32'h54, 32'hFFFF_FFFF, 32'd1, 32'd0, ALU_SLTU, 0, SRCB_RS2);
        cycle("sltu", 0, 0, 0, mk(1, 32'h54, 32'd0, 32'd1, 0, 0, 0, 2'd0));
        op(32'h58, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h1234_5678, ALU_XOR, 0, SRCB_RS2_B);
        cycle("xor_srcb3", 0, 0, 0, mk(1, 32'h58, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0, 2'd0));
        op(32'h1000, 32'h55, 32'd9, 32'h2000, ALU_ADD, 0, SRCB_PC_IMM);
        cycle("auipc", 0, 0, 0, mk(1, 32'h1000, 32'h3000, 32'd9, 0, 0, 0, 2'd0));
        op(32'h60, 32'd1, 32'd0, 32'h23, ALU_SLL, 0, SRCB_IMM);
        cycle("sll", 0, 0, 0, mk(1, 32'h60, 32'd8, 32'd0, 0, 0, 0, 2'd0));
        op(32'h64, 32'hF0, 32'h0F, 32'd0, ALU_OR, 0, SRCB_RS2);
        cycle("or", 0, 0, 0, mk(1, 32'h64, 32'hFF, 32'h0F, 0, 0, 0, 2'd0));
        op(32'h68, 32'hFF00, 32'h0FF0, 32'd0, ALU_AND, 0, SRCB_RS2);
        cycle("and", 0, 0, 0, mk(1, 32'h68, 32'h0F00, 32'h0FF0, 0, 0, 0, 2'd0));

        // Branches not taken
        op(32'h80, 32'd3, 32'd3, 32'h10, ALU_ADD, 0, SRCB_RS2);
        bus.branch_E = 1; bus.br_cond_E = BR_NE;
        cycle("bne_nt", 0, 1, 32'h90, mk(1, 32'h80, 32'd6, 32'd3, 0, 0, 0, 2'd0));
        op(32'h84, 32'd3, 32'd3, 32'h10, ALU_ADD, 0, SRCB_RS2);
        bus.branch_E = 1; bus.br_cond_E = 3'b010;
        cycle("br010", 0, 0, 0, mk(1, 32'h84, 32'd6, 32'd3, 0, 0, 0, 2'd0));
        op(32'h88, 32'hFFFF_FFFE, 32'd1, 32'h8, ALU_ADD, 0, SRCB_RS2);
        bus.branch_E = 1; bus.br_cond_E = BR_LTU;
        cycle("bltu_nt", 0, 0, 0, mk(1, 32'h88, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 2'd0));

        // BEQ taken, then the wrong-path instruction is killed even with jump set
        op(32'h100, 32'd3, 32'd3, 32'h20, ALU_ADD, 0, SRCB_RS2);
        bus.branch_E = 1; bus.br_cond_E = BR_EQ;
        cycle("beq_t", 1, 1, 32'h120, mk(1, 32'h100, 32'd6, 32'd3, 0, 0, 0, 2'd0));
        op(32'h104, 32'd1, 32'd2, 32'd0, ALU_ADD, 0, SRCB_RS2);
        bus.regWrite_E = 1; bus.memRead2_E = 1; bus.jump_E = 1; bus.rf_wr_sel_E = WR_SEL_MEM;
        cycle("killed", 0, 0, 0, mk(0, 32'h104, 32'd3, 32'd2, 0, 0, 0, 2'd2));

        // External flush
        op(32'h108, 32'h10, 32'd0, 32'd4, ALU_ADD, 0, SRCB_IMM);
        bus.jump_E = 1; bus.regWrite_E = 1; bus.flush_E = 1;
        cycle("flush", 0, 0, 0, mk(0, 32'h108, 32'h14, 32'd0, 0, 0, 0, 2'd0));

        // JALR under a 3-cycle stall, then flush+stall together, then release
        for (int i = 0; i < 3; i++) begin
            op(32'h200, 32'h203, 32'h77, 32'd0, ALU_ADD, 0, SRCB_IMM);
            bus.jump_E = 1; bus.regWrite_E = 1; bus.rf_wr_sel_E = WR_SEL_PC4; bus.stall_M = 1;
            cycle("jalr_stall", 1, 1, 32'h202, last);
        end
        op(32'h200, 32'h203, 32'h77, 32'd0, ALU_ADD, 0, SRCB_IMM);
        bus.jump_E = 1; bus.regWrite_E = 1; bus.stall_M = 1; bus.flush_E = 1;
        cycle("stall_flush", 0, 1, 32'h202, last);
        op(32'h200, 32'h203, 32'h77, 32'd0, ALU_ADD, 0, SRCB_IMM);
        bus.jump_E = 1; bus.regWrite_E = 1; bus.rf_wr_sel_E = WR_SEL_PC4;
        cycle("jalr", 1, 1, 32'h202, mk(1, 32'h200, 32'h203, 32'h77, 1, 0, 0, 2'd0));

        // SQ1 held by a stall, then the kill lands, then normal flow resumes
        op(32'h204, 32'd1, 32'd1, 32'd0, ALU_ADD, 0, SRCB_RS2);
        bus.jump_E = 1; bus.regWrite_E = 1; bus.stall_M = 1;
        cycle("sq1_stall", 0, 0, 0, last);
        op(32'h204, 32'd1, 32'd1, 32'd0, ALU_ADD, 0, SRCB_RS2);
        bus.jump_E = 1; bus.regWrite_E = 1;
        cycle("sq1_kill", 0, 0, 0, mk(0, 32'h204, 32'd2, 32'd1, 0, 0, 0, 2'd0));
        op(32'h300, 32'd1, 32'd1, 32'd0, ALU_ADD, 0, SRCB_RS2);
        bus.regWrite_E = 1;
        cycle("resume", 0, 0, 0, mk(1, 32'h300, 32'd2, 32'd1, 1, 0, 0, 2'd0));

        // Reset while in SQ1 with a store in M clears everything and the pending kill
        op(32'h400, 32'd0, 32'd0, 32'h8, ALU_ADD, 0, SRCB_RS2);
        bus.branch_E = 1; bus.br_cond_E = BR_EQ; bus.memWrite_E = 1;
        cycle("beq_store", 1, 1, 32'h408, mk(1, 32'h400, 32'd0, 32'd0, 0, 1, 0, 2'd0));
        op(32'h404, 32'd1, 32'd2, 32'd0, ALU_ADD, 0, SRCB_RS2);
        bus.memWrite_E = 1; RST = 1;
        cycle("rst_sq1", 0, 0, 0, zero_m);
        op(32'h500, 32'd2, 32'h30, 32'd0, ALU_ADD, 0, SRCB_RS2);
        bus.memWrite_E = 1;
        cycle("post_rst", 0, 0, 0, mk(1, 32'h500, 32'h32, 32'h30, 0, 1, 0, 2'd0));

        clr();
        @(posedge CLK);
        #3;
        chk("scoreboard_drained", 32'(scb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
